// File: rtl/seq_link_pkg.sv
// Shared definitions for the 11101 sync-marker serial link (transmitter and detector).
package seq_link_pkg;

    // Frame marker, sent MSB first.
    localparam int              SYNC_W       = 5;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 5'b11101;

    // Longest run of payload ones allowed before a stuff 0 is inserted.
    localparam logic [1:0]      RUN_MAX      = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DATA  = 2'd2,
        STUFF = 2'd3
    } tx_state_t;

endpackage

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync marker followed by a zero-stuffed payload.
// All outputs are registered; the state register always describes the bit
// currently on dataout, and cnt holds that bit's index within its field.
module seq_frame_tx #(
    parameter int                SYNC_W       = seq_link_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = seq_link_pkg::SYNC_PATTERN,
    parameter int                PAYLOAD_W    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PAYLOAD_W-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 dataout,
    output logic                 frame_active,
    output logic                 stuff_bit
);

    import seq_link_pkg::tx_state_t;
    import seq_link_pkg::IDLE;
    import seq_link_pkg::SYNC;
    import seq_link_pkg::DATA;
    import seq_link_pkg::STUFF;
    import seq_link_pkg::RUN_MAX;

    // Bits still to be sent after the first sync bit goes out at the handshake edge.
    localparam int FR_W  = SYNC_W - 1 + PAYLOAD_W;
    localparam int MAX_W = (SYNC_W > PAYLOAD_W) ? SYNC_W : PAYLOAD_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    tx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       run, run_n;
    logic [FR_W-1:0]  frame_sr, frame_sr_n;
    logic             dout_n, active_n, stuff_n;
    logic             next_bit;

    // Run length of ones after sending one more bit; saturates at RUN_MAX.
    function automatic logic [1:0] run_after(input logic [1:0] run_in, input logic bit_in);
        if (!bit_in)
            return 2'd0;
        if (run_in >= RUN_MAX)
            return RUN_MAX;
        return run_in + 2'd1;
    endfunction

    assign next_bit = frame_sr[FR_W-1];
    assign tx_ready = (state == IDLE);

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            run          <= 2'd0;
            frame_sr     <= '0;
            dataout      <= 1'b0;
            frame_active <= 1'b0;
            stuff_bit    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            run          <= run_n;
            frame_sr     <= frame_sr_n;
            dataout      <= dout_n;
            frame_active <= active_n;
            stuff_bit    <= stuff_n;
        end
    end

    // Next-state and next-output decode; outputs default to the idle line.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        run_n      = run;
        frame_sr_n = frame_sr;
        dout_n     = 1'b0;
        active_n   = 1'b0;
        stuff_n    = 1'b0;

        case (state)
            IDLE: begin
                run_n = 2'd0;
                if (tx_valid) begin
                    // First sync bit goes out on the handshake edge itself.
                    state_n    = SYNC;
                    cnt_n      = CNT_W'(SYNC_W - 1);
                    frame_sr_n = {SYNC_PATTERN[SYNC_W-2:0], tx_data};
                    dout_n     = SYNC_PATTERN[SYNC_W-1];
                    active_n   = 1'b1;
                end
            end

            SYNC: begin
                active_n   = 1'b1;
                dout_n     = next_bit;
                frame_sr_n = {frame_sr[FR_W-2:0], 1'b0};
                if (cnt == '0) begin
                    // Marker ends in a 1, so the payload starts with a run of one.
                    state_n = DATA;
                    cnt_n   = CNT_W'(PAYLOAD_W - 1);
                    run_n   = run_after(2'd1, next_bit);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            DATA: begin
                if (run == RUN_MAX) begin
                    // Break the run of ones; cnt stays on the bit just sent.
                    state_n  = STUFF;
                    run_n    = 2'd0;
                    dout_n   = 1'b0;
                    active_n = 1'b1;
                    stuff_n  = 1'b1;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                    run_n   = 2'd0;
                end else begin
                    active_n   = 1'b1;
                    dout_n     = next_bit;
                    frame_sr_n = {frame_sr[FR_W-2:0], 1'b0};
                    cnt_n      = cnt - CNT_W'(1);
                    run_n      = run_after(run, next_bit);
                end
            end

            STUFF: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    run_n   = 2'd0;
                end else begin
                    state_n    = DATA;
                    active_n   = 1'b1;
                    dout_n     = next_bit;
                    frame_sr_n = {frame_sr[FR_W-2:0], 1'b0};
                    cnt_n      = cnt - CNT_W'(1);
                    run_n      = run_after(2'd0, next_bit);
                end
            end

            default: begin
                state_n = IDLE;
                run_n   = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: expected line bits are queued when a
// payload is handed over and popped by a monitor on every active frame cycle.
module tb_seq_frame_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       dataout;
    logic       frame_active;
    logic       stuff_bit;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [1:0] exp_q[$];      // {stuff, bit} per expected frame cycle
    bit         mon_en = 1'b0;
    int         fa_cnt = 0;
    int         st_cnt = 0;
    logic [4:0] det_sr = 5'b0;
    int         det_hits = 0;

    seq_frame_tx dut (
        .clock        (clock),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .dataout      (dataout),
        .frame_active (frame_active),
        .stuff_bit    (stuff_bit)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clock) begin
        logic [1:0] e;
        if (mon_en) begin
            det_sr = {det_sr[3:0], dataout};
            if (det_sr == 5'b11101) det_hits++;
            if (frame_active) begin
                fa_cnt++;
                if (stuff_bit) st_cnt++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_bit: dataout=%b stuff_bit=%b while no frame bit was expected", dataout, stuff_bit);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_ready, stuff_bit, dataout} !== {1'b0, e})
                        $display("FAIL frame_bit: got ready/stuff/data=%b%b%b expected 0%b%b", tx_ready, stuff_bit, dataout, e[1], e[0]);
                    else
                        pass_cnt++;
                end
            end else begin
                total_cnt++;
                if (dataout !== 1'b0 || stuff_bit !== 1'b0)
                    $display("FAIL idle_line: dataout=%b stuff_bit=%b expected 0 0", dataout, stuff_bit);
                else
                    pass_cnt++;
            end
        end
    end

    // Reference frame: marker, then payload MSB first with a 0 after every two ones.
    task automatic push_frame(input logic [7:0] d);
        logic [4:0] sync;
        int         run;
        sync = 5'b11101;
        for (int i = 4; i >= 0; i--) exp_q.push_back({1'b0, sync[i]});
        run = 1;
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back({1'b0, d[i]});
            run = d[i] ? run + 1 : 0;
            if (run == 2) begin
                exp_q.push_back(2'b10);
                run = 0;
            end
        end
    endtask

    // Single handshake from an idle point; returns 1 time unit after the handshake edge.
    task automatic send(input logic [7:0] d);
        push_frame(d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clock); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        total_cnt++;
        if ({tx_ready, dataout, frame_active, stuff_bit} !== 4'b1000)
            $display("FAIL reset_outputs: ready/data/active/stuff=%b expected 1000", {tx_ready, dataout, frame_active, stuff_bit});
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clock); #1;
        total_cnt++;
        if ({tx_ready, dataout, frame_active, stuff_bit} !== 4'b1000)
            $display("FAIL after_reset_idle: ready/data/active/stuff=%b expected 1000", {tx_ready, dataout, frame_active, stuff_bit});
        else pass_cnt++;
        mon_en = 1'b1;
    endtask

    task automatic test_single_frame(input logic [7:0] d, input int exp_len, input int exp_stuffs);
        fa_cnt = 0; st_cnt = 0;
        send(d);
        total_cnt++;
        if ({dataout, tx_ready, frame_active} !== 3'b101)
            $display("FAIL first_sync_bit %h: data/ready/active=%b expected 101", d, {dataout, tx_ready, frame_active});
        else pass_cnt++;
        repeat (20) @(posedge clock);
        #1;
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL frame_complete %h: %0d bits outstanding expected 0", d, exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        total_cnt++;
        if (fa_cnt != exp_len) $display("FAIL frame_len %h: got %0d expected %0d", d, fa_cnt, exp_len);
        else pass_cnt++;
        total_cnt++;
        if (st_cnt != exp_stuffs) $display("FAIL stuff_count %h: got %0d expected %0d", d, st_cnt, exp_stuffs);
        else pass_cnt++;
        total_cnt++;
        if ({tx_ready, dataout, frame_active} !== 3'b100)
            $display("FAIL end_idle %h: ready/data/active=%b expected 100", d, {tx_ready, dataout, frame_active});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int   hs, gap;
        logic rdy_before, vld_before;
        hs = 0; gap = 0; det_hits = 0; det_sr = 5'b0; fa_cnt = 0;
        push_frame(8'h5A);
        push_frame(8'h3C);
        tx_data = 8'h5A; tx_valid = 1'b1;
        for (int c = 0; c < 80 && (hs < 2 || exp_q.size() > 0); c++) begin
            rdy_before = tx_ready;
            vld_before = tx_valid;
            @(posedge clock); #1;
            if (rdy_before && vld_before) begin
                hs++;
                if (hs == 1) tx_data = 8'h3C;
                else tx_valid = 1'b0;
            end
            if (hs == 1 && !frame_active) gap++;
        end
        tx_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total_cnt++;
        if (hs != 2) $display("FAIL b2b_handshakes: got %0d expected 2", hs);
        else pass_cnt++;
        total_cnt++;
        if (gap != 1) $display("FAIL b2b_gap: got %0d idle cycles expected 1", gap);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_complete: %0d bits outstanding expected 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        total_cnt++;
        if (fa_cnt != 29) $display("FAIL b2b_len: got %0d expected 29", fa_cnt);
        else pass_cnt++;
        total_cnt++;
        if (det_hits != 2) $display("FAIL b2b_marker_hits: got %0d expected 2", det_hits);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        mon_en = 1'b0;
        send(8'h00);
        repeat (7) @(posedge clock);
        #1;
        total_cnt++;
        if ({frame_active, tx_ready} !== 2'b10)
            $display("FAIL abort_midframe: active/ready=%b expected 10", {frame_active, tx_ready});
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clock); #1;
        total_cnt++;
        if ({tx_ready, dataout, frame_active, stuff_bit} !== 4'b1000)
            $display("FAIL abort_reset_outputs: ready/data/active/stuff=%b expected 1000", {tx_ready, dataout, frame_active, stuff_bit});
        else pass_cnt++;
        reset = 1'b0;
        exp_q.delete();
        det_sr = 5'b0;
        mon_en = 1'b1;
        test_single_frame(8'h00, 13, 0);
    endtask

    task automatic test_ignore_midframe();
        fa_cnt = 0; st_cnt = 0;
        send(8'hA5);
        repeat (3) @(posedge clock);
        #1;
        tx_data = 8'hFF; tx_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tx_valid = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL ignore_complete: %0d bits outstanding expected 0", exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        total_cnt++;
        if (fa_cnt != 14) $display("FAIL ignore_len: got %0d expected 14", fa_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({tx_ready, dataout, frame_active} !== 3'b100)
            $display("FAIL ignore_idle: ready/data/active=%b expected 100", {tx_ready, dataout, frame_active});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame(8'h00, 13, 0);
        test_single_frame(8'hFF, 17, 4);
        test_single_frame(8'hA5, 14, 1);
        test_back_to_back();
        test_reset_abort();
        test_ignore_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
